// File: rtl/hlsm_shared_adder_ctrl.sv
// ============================================================================
// hlsm_shared_adder_ctrl
//
// Purpose:
//   Computes the 5-operand signed sum i = a + b + c + d + e with a single
//   DATA_WIDTH-bit adder that is reused across the four additions. A small
//   FSM sequences the adder and provides a Start/Done/Busy handshake.
//   This trades throughput (one result per 5 cycles at most) for area
//   compared with a fully pipelined sum chain.
//
// Optional build macro:
//   HLSM_SAT_EN - when defined, every partial sum saturates to the signed
//                 DATA_WIDTH range instead of wrapping. Timing and handshake
//                 are identical in both builds.
//
// Ports:
//   Clk        in   1           rising-edge clock
//   Rst        in   1           asynchronous active-low reset
//   Start      in   1           operation request, sampled only in IDLE
//   a..e       in   DATA_WIDTH  signed operands, sampled on the accepting edge
//   i          out  DATA_WIDTH  signed result register (held until overwritten)
//   Done       out  1           one-cycle completion pulse
//   Busy       out  1           high while an operation is in flight
// ============================================================================
module hlsm_shared_adder_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int N_ADDS     = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Start,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] c,
    input  logic signed [DATA_WIDTH-1:0] d,
    input  logic signed [DATA_WIDTH-1:0] e,
    output logic signed [DATA_WIDTH-1:0] i,
    output logic                         Done,
    output logic                         Busy
);

    localparam int CW = (N_ADDS > 1) ? $clog2(N_ADDS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_ADDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t                        r_state;
    logic [CW-1:0]                 r_cnt;
    logic signed [DATA_WIDTH-1:0]  r_acc;
    logic signed [DATA_WIDTH-1:0]  r_op [0:N_ADDS-1];
    logic signed [DATA_WIDTH-1:0]  r_i;
    logic                          r_done;
    logic                          r_busy;

    state_t                        w_state_nxt;
    logic [CW-1:0]                 w_cnt_nxt;
    logic signed [DATA_WIDTH-1:0]  w_acc_nxt;
    logic signed [DATA_WIDTH-1:0]  w_op_nxt [0:N_ADDS-1];
    logic signed [DATA_WIDTH-1:0]  w_i_nxt;
    logic                          w_done_nxt;
    logic                          w_busy_nxt;

    logic signed [DATA_WIDTH-1:0]  w_addend;
    logic signed [DATA_WIDTH-1:0]  w_sum;

`ifdef HLSM_SAT_EN
    // Signed add with clamping. Overflow happens only when both inputs share a
    // sign and the wrapped result has the opposite sign; the clamp direction
    // follows the input sign.
    function automatic logic signed [DATA_WIDTH-1:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [DATA_WIDTH-1:0] y
    );
        logic signed [DATA_WIDTH-1:0] s;
        s = x + y;
        if ((x[DATA_WIDTH-1] == y[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != x[DATA_WIDTH-1])) begin
            if (x[DATA_WIDTH-1]) begin
                s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end else begin
            s = s;
        end
        return s;
    endfunction
`endif

    // Shared adder: the counter selects which stored operand is added to acc.
    always_comb begin
        w_addend = r_op[r_cnt];
`ifdef HLSM_SAT_EN
        w_sum    = sat_add(r_acc, w_addend);
`else
        w_sum    = r_acc + w_addend;
`endif
    end

    // Next-state and next-register logic for the sequencing FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_op_nxt    = r_op;
        w_i_nxt     = r_i;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = r_busy;

        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_acc_nxt   = a;
                    w_op_nxt[0] = b;
                    w_op_nxt[1] = c;
                    w_op_nxt[2] = d;
                    w_op_nxt[3] = e;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_ADD;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_ADD: begin
                // Start is not looked at here: requests while busy are dropped.
                w_acc_nxt = w_sum;
                if (r_cnt == LAST_CNT) begin
                    w_i_nxt     = w_sum;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and handshake registers; reset aborts any in-flight operation.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_i    <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
            for (int k = 0; k < N_ADDS; k++) begin
                r_op[k] <= '0;
            end
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_acc  <= w_acc_nxt;
            r_i    <= w_i_nxt;
            r_done <= w_done_nxt;
            r_busy <= w_busy_nxt;
            for (int k = 0; k < N_ADDS; k++) begin
                r_op[k] <= w_op_nxt[k];
            end
        end
    end

    assign i    = r_i;
    assign Done = r_done;
    assign Busy = r_busy;

endmodule

// File: doc/hlsm_shared_adder_ctrl.md
Name: hlsm_shared_adder_ctrl

Overview:
Resource-constrained controller for the 5-operand signed sum chain (i = a+b+c+d+e).
- Time-multiplexes one DATA_WIDTH adder across the four additions instead of four pipelined adders.
- Sequences the adder with an FSM and provides a Start/Done/Busy handshake.
- Drop-in alternative to the fully pipelined sum-chain HLSM when area matters more than throughput.

Parameters:
- DATA_WIDTH, 16, width of every operand, partial sum and result; two's complement signed.
- N_ADDS, 4, number of additions performed (operands = N_ADDS+1); fixed at 4 for this revision, kept for the bench.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- a, b, c, d, e  input  DATA_WIDTH each  signed operands; sampled on the accepting edge only.
- i  output  DATA_WIDTH  signed result register.
- Done  output  1  one-cycle completion pulse; i valid while Done=1 and held afterwards.
- Busy  output  1  high while an operation is in flight (states ADD).

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, cnt=0, acc=0, operand regs=0, i=0, Done=0, Busy=0. Any in-flight operation is aborted; no Done for it.
- States:
  - IDLE: Busy=0.
  - ADD: Busy=1; cnt runs 0..N_ADDS-1.
- IDLE, Start=1 at edge E0:
  - acc<=a; opreg[0..3]<=b,c,d,e; cnt<=0; state<=ADD; Busy<=1.
  - Start=0: remain IDLE, registers hold.
- ADD, edges E1..E4:
  - Single adder computes acc + opreg[cnt]; acc<=sum; cnt<=cnt+1.
  - At E4 (cnt=3): i<=sum; Done<=1; Busy<=0; state<=IDLE; cnt<=0.
- Done timing: Done registered; high for exactly the cycle after E4, cleared at E5 unless a new completion occurs (impossible by construction).
- Latency: Start sampled at E0 → Done/i valid after E4 (4 cycles).
- Throughput: Start at E5 (during the Done cycle) is accepted. Max one result per 5 cycles. Start held high continuously gives back-to-back operations, accepted at E0, E5, E10, ...
- Start while Busy=1: ignored, not queued. Operands changing during ADD have no effect.
- Arithmetic: DATA_WIDTH-bit two's complement, wrap-around on overflow at every partial sum. No extra width carried.
- i holds its last value across IDLE and during the next operation until overwritten at that operation's E4.
- Exactly one adder instance. Adder input mux is selected by cnt; no additional arithmetic units.

Optional Feature:
- Macro HLSM_SAT_EN.
- Defined: each partial sum saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Overflow is detected from operand signs vs. result sign and clamped before writing acc/i. Saturation applies per step, not only at the end.
- Undefined: plain wrap-around; no saturation logic synthesised.
- Timing and handshake are identical in both builds.

Test Plan:
- Basic: Rst low then high; Start=1 one cycle with a..e=1,2,3,4,5 → Busy=1 for 4 cycles, Done=1 for one cycle after E4, i=15; i still 15 ten cycles later.
- Signed: a..e=-100,50,-25,10,-1 → i=-66; Done pulse width exactly 1 cycle.
- Overflow: a..e=32767,1,0,0,0 → i=-32768 without HLSM_SAT_EN, i=32767 with it. Also a..e=32767,1,-1,0,0 → -32768+(-1) wraps to 32767 without the macro; with it, 32767 then 32766.
- Busy rejection: Start at E0 (1..5), Start pulsed again at E2 with a..e=10,10,10,10,10 → single Done, i=15; no second Done within the next 10 cycles.
- Back-to-back: Start held high, operand sets (1,1,1,1,1) then (2,2,2,2,2) → Done at cycles 5 and 10 after first accept, i=5 then 10.
- Reset mid-operation: Start (1..5), Rst low asynchronously between E2 and E3 → i=0, Done=0, Busy=0 immediately. After release, no Done until a new Start; new Start (3,3,3,3,3) → i=15.
